// File: rtl/ternary_vector_reducer.sv
// Folds a multi-beat frame of N-trit words into one N-trit result using a
// per-frame ternary operator (min, max, any, consensus), with beat count and illegal-code flag.
module ternary_vector_reducer #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  in_data,
  input  logic            in_last,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_data,
  output logic [CW-1:0]   out_count,
  output logic            err,
  output logic [1:0]      dbg_state
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. Neither valid may depend on its ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] COUNT_MAX = '1;

  state_t          state;
  state_t          state_next;
  logic [1:0]      op_q;
  logic [2*N-1:0]  norm;
  logic [2*N-1:0]  folded;
  logic            illegal;
  logic            accept;

  function automatic logic [1:0] trit_op(input logic [1:0] f, input logic [1:0] x,
                                         input logic [1:0] y);
    logic [1:0] r;
    r = 2'b01;
    case (f)
      2'b00: r = (x < y) ? x : y;
      2'b01: r = (x > y) ? x : y;
      2'b10: begin
        if (x == y)          r = x;
        else if (x == 2'b01) r = y;
        else if (y == 2'b01) r = x;
        else                 r = 2'b01;
      end
      default: r = (x == y) ? x : 2'b01;
    endcase
    return r;
  endfunction

  // Illegal code 11 is treated as the value 1 before it reaches any operator.
  always_comb begin
    norm    = '0;
    illegal = 1'b0;
    folded  = '0;
    for (int i = 0; i < N; i++) begin
      if (in_data[2*i +: 2] == 2'b11) begin
        norm[2*i +: 2] = 2'b01;
        illegal        = 1'b1;
      end else begin
        norm[2*i +: 2] = in_data[2*i +: 2];
      end
      folded[2*i +: 2] = trit_op(op_q, out_data[2*i +: 2], norm[2*i +: 2]);
    end
  end

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: if (accept) state_next = in_last ? DONE : ACCUM;
      DONE:        if (out_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      out_data  <= '0;
      out_count <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (state == IDLE) begin
          op_q      <= op;
          out_data  <= norm;
          out_count <= CW'(1);
          err       <= illegal;
        end else begin
          out_data <= folded;
          if (out_count != COUNT_MAX) out_count <= out_count + CW'(1);
          err <= err | illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_vector_reducer.sv
// Bench for ternary_vector_reducer: a CW=8 and a CW=2 instance share stimulus;
// results are checked against an expected queue filled from a vector table and a trit model.
module tb_ternary_vector_reducer;

  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int EW = 1 + 8 + W;

  typedef struct {
    logic [1:0]          op;
    int                  n;
    logic [5:0][W-1:0]   beats;
    logic [W-1:0]        exp_data;
    logic [7:0]          exp_count;
    logic                exp_err;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          in_valid, in_last, out_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    op;
  logic          in_ready, out_valid, err;
  logic [W-1:0]  out_data;
  logic [7:0]    out_count;
  logic [1:0]    dbg_state;
  logic          in_ready2, out_valid2, err2;
  logic [W-1:0]  out_data2;
  logic [1:0]    out_count2;
  logic [1:0]    dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  vec_t tbl[8];

  ternary_vector_reducer #(.N(N), .CW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .err(err), .dbg_state(dbg_state)
  );

  ternary_vector_reducer #(.N(N), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .op(op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
    .err(err2), .dbg_state(dbg_state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int tfun(input int o, input int x, input int y);
    case (o)
      0: return (x < y) ? x : y;
      1: return (x > y) ? x : y;
      2: begin
        if (x == y) return x;
        if (x == 1) return y;
        if (y == 1) return x;
        return 1;
      end
      default: return (x == y) ? x : 1;
    endcase
  endfunction

  function automatic logic [EW-1:0] model_frame(input logic [1:0] o, input int n,
                                                input logic [5:0][W-1:0] b);
    int v[N];
    int x;
    int cnt;
    logic e;
    logic [1:0] c;
    logic [W-1:0] d;
    e = 1'b0;
    d = '0;
    for (int j = 0; j < n; j++) begin
      for (int t = 0; t < N; t++) begin
        c = b[j][2*t +: 2];
        x = (c == 2'b11) ? 1 : int'(c);
        if (c == 2'b11) e = 1'b1;
        v[t] = (j == 0) ? x : tfun(int'(o), v[t], x);
      end
    end
    for (int t = 0; t < N; t++) d[2*t +: 2] = 2'(v[t]);
    cnt = (n > 255) ? 255 : n;
    return {e, 8'(cnt), d};
  endfunction

  function automatic vec_t mk(input logic [1:0] o, input int n,
                              input logic [W-1:0] b0, input logic [W-1:0] b1,
                              input logic [W-1:0] b2, input logic [W-1:0] b3,
                              input logic [W-1:0] b4, input logic [W-1:0] b5,
                              input logic [W-1:0] d, input logic [7:0] c, input logic e);
    vec_t v;
    v.op = o; v.n = n;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.beats[3] = b3; v.beats[4] = b4; v.beats[5] = b5;
    v.exp_data = d; v.exp_count = c; v.exp_err = e;
    return v;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic last, input logic [1:0] o);
    int waits;
    waits = 0;
    in_valid = 1'b1; in_data = d; in_last = last; op = o;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1 t=%0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Non-first beats drive a different op so the latched op is exercised on every frame.
  task automatic send_frame(input logic [1:0] o, input int n, input logic [5:0][W-1:0] b,
                            input logic [EW-1:0] e, input bit gaps);
    for (int j = 0; j < n; j++) begin
      if (j > 0 && gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (j == n - 1) exp_q.push_back(e);
      send_beat(b[j], (j == n - 1), (j == 0) ? o : (o ^ 2'b01));
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [7:0] sat;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=%0h required=none t=%0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        sat = (e[W +: 8] > 8'd3) ? 8'd3 : e[W +: 8];
        check("out_data", 32'(out_data), 32'(e[W-1:0]));
        check("out_count", 32'(out_count), 32'(e[W +: 8]));
        check("err", 32'(err), 32'(e[EW-1]));
        check("sat_out_valid", 32'(out_valid2), 32'd1);
        check("sat_out_data", 32'(out_data2), 32'(e[W-1:0]));
        check("sat_out_count", 32'(out_count2), 32'(sat));
        check("sat_err", 32'(err2), 32'(e[EW-1]));
      end
    end
  end

  initial begin
    logic [5:0][W-1:0] b;
    logic [1:0] ro;
    int rn;
    tbl[0] = mk(2'd0, 2, 8'hA4, 8'h6A, 0, 0, 0, 0, 8'h64, 8'd2, 1'b0);
    tbl[1] = mk(2'd3, 3, 8'h92, 8'h98, 8'h92, 0, 0, 0, 8'h95, 8'd3, 1'b0);
    tbl[2] = mk(2'd2, 2, 8'h18, 8'hA5, 0, 0, 0, 0, 8'h68, 8'd2, 1'b0);
    tbl[3] = mk(2'd1, 1, 8'h03, 0, 0, 0, 0, 0, 8'h01, 8'd1, 1'b1);
    tbl[4] = mk(2'd0, 1, 8'h12, 0, 0, 0, 0, 0, 8'h12, 8'd1, 1'b0);
    tbl[5] = mk(2'd1, 6, 8'h00, 8'h01, 8'h04, 8'h10, 8'h40, 8'h00, 8'h55, 8'd6, 1'b0);
    tbl[6] = mk(2'd0, 2, 8'hAA, 8'hFF, 0, 0, 0, 0, 8'h55, 8'd2, 1'b1);
    tbl[7] = mk(2'd3, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h55, 8'd1, 1'b1);

    in_valid = 1'b0; in_last = 1'b0; in_data = '0; op = 2'b00; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i])
      send_frame(tbl[i].op, tbl[i].n, tbl[i].beats,
                 {tbl[i].exp_err, tbl[i].exp_count, tbl[i].exp_data}, 1'b1);

    // backpressure: result held in DONE, extra beats refused
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd1, 8'h21});
    send_beat(8'h21, 1'b1, 2'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'h21);
      check("bp_out_count", 32'(out_count), 32'd1);
      in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1; op = 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_exit_in_ready", 32'(in_ready), 32'd1);
    check("bp_exit_out_valid", 32'(out_valid), 32'd0);
    check("bp_exit_state", 32'(dbg_state), 32'd0);

    // reset in ACCUM discards the partial frame
    send_beat(8'h5A, 1'b0, 2'd1);
    send_beat(8'h12, 1'b0, 2'd1);
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    b = '0;
    b[0] = 8'h26;
    send_frame(2'd0, 1, b, {1'b0, 8'd1, 8'h26}, 1'b0);

    // random frames against the trit model
    for (int r = 0; r < 16; r++) begin
      ro = 2'($urandom_range(0, 3));
      rn = $urandom_range(1, 6);
      for (int j = 0; j < 6; j++) b[j] = 8'($urandom_range(0, 255));
      send_frame(ro, rn, b, model_frame(ro, rn, b), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_vector_reducer.md
Name: ternary_vector_reducer

Overview:
Parametrised successor to the single-trit ternary gates. Applies one of four trit-wise ternary operators (min, max, any, consensus) across N-trit words and folds a multi-beat frame into a single N-trit result. Sits between a ternary data source and a consumer, with a valid/ready handshake on both sides. Reports beat count and an illegal-code flag per frame.

Parameters:
N, 4, trits per word (≥1); each trit is 2 bits, so the data width is 2N.
CW, 8, beat-counter width (≥1).

Ports:
clk  in  1  clock; everything is rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  2N  trit i is bits [2i+1:2i] = {t1,t0}.
in_last  in  1  beat is the final beat of its frame.
op  in  2  00 min, 01 max, 10 any, 11 consensus; sampled on the first beat of a frame only.
out_valid  out  1  frame result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  2N  folded result, same encoding as in_data.
out_count  out  CW  beats in the frame, saturating at 2^CW-1.
err  out  1  the frame contained at least one illegal trit; valid with out_valid.

Behaviour:
- Trit encoding {t1,t0}: 00=0, 01=1, 10=2. Code 11 is illegal; it is replaced by 1 (01) before any op and sets the frame error flag.
- Operators, applied per trit to (x,y):
  - min: smaller value. max: larger value.
  - consensus: x if x==y, else 1.
  - any: x if x==y; otherwise the other operand if one of them is 1; otherwise 1 (the 0/2 case).
- Beat accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. An accepted beat latches op, sets acc=normalised in_data, count=1, err=illegal-in-beat.
    - in_last=1 → DONE; else → ACCUM.
  - ACCUM: in_ready=1. An accepted beat sets acc=f_op(acc, normalised in_data), count=sat(count+1), err|=illegal.
    - in_last=1 → DONE. No beat → stay in ACCUM.
  - DONE: in_ready=0, out_valid=1, and out_data/out_count/err are stable. out_ready=1 → IDLE on the next edge.
- Latency: last beat accepted at edge k gives out_valid=1 after edge k. A single-beat frame returns the normalised word, count=1.
- Handshake: out_valid stays high and the outputs hold until out_ready. in_ready returns to 1 the cycle after the output handshake. in_data is never accepted in the same cycle as a DONE handshake.
- op changes mid-frame are ignored. The latched op is used until DONE exits.
- out_count saturation: it holds at 2^CW-1 and does not wrap.
- Reset values (immediate, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_data=0, out_count=0, err=0, latched op=00.
- Reset mid-frame or during DONE discards the frame; no output is produced for it.
- in_valid=0 in any state leaves state and acc unchanged.

Test Plan:
- N=4, op=min, frame {2,2,1,0} then {1,2,2,2} (trit3..0), last on beat 2: out_data=trits {1,2,1,0}, count=2, err=0, out_valid exactly one cycle after the last beat.
- op=consensus, frame {2,1,0,2},{2,1,2,0},{2,1,0,2}: result {2,1,1,1}, count=3. Then op=any on {0,1,2,0},{2,2,1,1}: result {1,2,2,0}.
- op=max, single beat with trit0=11 and others 0: out_data=trits {0,0,0,1}, count=1, err=1. The next frame (clean) reports err=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: in_ready=0, outputs stable, extra in_valid beats not accepted. Then out_ready=1 gives IDLE next cycle and in_ready=1.
- CW=2, 6-beat frame with op=max: count saturates at 3. Change op to min mid-frame: the result still reflects max.
- Assert reset in ACCUM after 2 beats: out_valid stays 0 and in_ready=1 immediately. A following 1-beat frame returns that word with count=1.
